// File: rtl/ws2812_decoder.sv
// WS2812 NRZ line receiver: recovers 24-bit pixel words and frame
// boundaries by measuring high-pulse widths in clk cycles.
module ws2812_decoder #(
  parameter int PX_COUNT_WIDTH = 6,
  parameter int BITS_PER_PIXEL = 24,
  parameter int MIN_HIGH       = 15,
  parameter int BIT_THRESH     = 60,
  parameter int MAX_HIGH       = 120,
  parameter int RESET_CYCLES   = 5000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      din,
  output logic [BITS_PER_PIXEL-1:0] pixel_data,
  output logic                      pixel_valid,
  output logic [PX_COUNT_WIDTH-1:0] pixel_index,
  output logic                      frame_done,
  output logic [PX_COUNT_WIDTH-1:0] frame_px_count,
  output logic                      err,
  output logic                      err_sticky
);

  localparam int HW = $clog2(MAX_HIGH + 2);
  localparam int LW = $clog2(RESET_CYCLES + 1);
  localparam int BW = $clog2(BITS_PER_PIXEL);
  localparam int PW = PX_COUNT_WIDTH;
  localparam int DW = BITS_PER_PIXEL;

  localparam logic [HW-1:0] HI_SAT   = HW'(MAX_HIGH + 1);
  localparam logic [HW-1:0] HI_MIN   = HW'(MIN_HIGH);
  localparam logic [HW-1:0] HI_ONE   = HW'(BIT_THRESH);
  localparam logic [LW-1:0] LO_GAP   = LW'(RESET_CYCLES);
  localparam logic [BW-1:0] BIT_LAST = BW'(BITS_PER_PIXEL - 1);

  typedef enum logic [2:0] {
    WAIT_GAP,
    IDLE,
    HIGH,
    LOW,
    ERROR
  } state_t;

  state_t        state_q, state_d;
  logic          s1_q, din_s_q, prev_q;
  logic [HW-1:0] hi_cnt_q, hi_cnt_d;
  logic [LW-1:0] lo_cnt_q, lo_cnt_d;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;
  logic [PW-1:0] px_cnt_q, px_cnt_d;
  logic [DW-1:0] shift_q, shift_d;
  logic [DW-1:0] pixel_data_q, pixel_data_d;
  logic          pixel_valid_q, pixel_valid_d;
  logic [PW-1:0] pixel_index_q, pixel_index_d;
  logic          frame_done_q, frame_done_d;
  logic [PW-1:0] frame_px_q, frame_px_d;
  logic          err_q, err_d;
  logic          err_sticky_q, err_sticky_d;

  logic          rise, fall, bit_val, gap;
  logic [DW-1:0] shifted;

  assign rise    = din_s_q & ~prev_q;
  assign fall    = ~din_s_q & prev_q;
  assign gap     = (lo_cnt_q == LO_GAP);
  assign bit_val = (hi_cnt_q >= HI_ONE);
  assign shifted = {shift_q[DW-2:0], bit_val};

  // Next-state: run counters, classify pulses, assemble pixels.
  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    px_cnt_d      = px_cnt_q;
    shift_d       = shift_q;
    pixel_data_d  = pixel_data_q;
    pixel_index_d = pixel_index_q;
    frame_px_d    = frame_px_q;
    pixel_valid_d = 1'b0;
    frame_done_d  = 1'b0;
    err_d         = 1'b0;
    if (din_s_q) begin
      hi_cnt_d = (hi_cnt_q == HI_SAT) ? hi_cnt_q : hi_cnt_q + 1'b1;
      lo_cnt_d = '0;
    end else begin
      hi_cnt_d = '0;
      lo_cnt_d = gap ? lo_cnt_q : lo_cnt_q + 1'b1;
    end
    unique case (state_q)
      WAIT_GAP, ERROR: begin
        if (gap) begin
          bit_cnt_d = '0;
          px_cnt_d  = '0;
          state_d   = rise ? HIGH : IDLE;
        end
      end
      IDLE: begin
        if (rise) state_d = HIGH;
      end
      HIGH: begin
        if (hi_cnt_q == HI_SAT) begin
          err_d   = 1'b1;
          state_d = ERROR;
        end else if (fall) begin
          if (hi_cnt_q < HI_MIN) begin
            err_d   = 1'b1;
            state_d = ERROR;
          end else begin
            shift_d = shifted;
            state_d = LOW;
            if (bit_cnt_q == BIT_LAST) begin
              pixel_data_d  = shifted;
              pixel_valid_d = 1'b1;
              pixel_index_d = px_cnt_q;
              px_cnt_d      = px_cnt_q + 1'b1;
              bit_cnt_d     = '0;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end
        end
      end
      LOW: begin
        if (gap) begin
          if (bit_cnt_q == '0) begin
            frame_done_d = 1'b1;
            frame_px_d   = px_cnt_q;
          end else begin
            err_d = 1'b1;
          end
          bit_cnt_d = '0;
          px_cnt_d  = '0;
          state_d   = rise ? HIGH : IDLE;
        end else if (rise) begin
          state_d = HIGH;
        end
      end
      default: state_d = WAIT_GAP;
    endcase
    err_sticky_d = err_sticky_q | err_d;
  end

  // State, synchronizer and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= WAIT_GAP;
      s1_q          <= 1'b0;
      din_s_q       <= 1'b0;
      prev_q        <= 1'b0;
      hi_cnt_q      <= '0;
      lo_cnt_q      <= '0;
      bit_cnt_q     <= '0;
      px_cnt_q      <= '0;
      shift_q       <= '0;
      pixel_data_q  <= '0;
      pixel_valid_q <= 1'b0;
      pixel_index_q <= '0;
      frame_done_q  <= 1'b0;
      frame_px_q    <= '0;
      err_q         <= 1'b0;
      err_sticky_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      s1_q          <= din;
      din_s_q       <= s1_q;
      prev_q        <= din_s_q;
      hi_cnt_q      <= hi_cnt_d;
      lo_cnt_q      <= lo_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      px_cnt_q      <= px_cnt_d;
      shift_q       <= shift_d;
      pixel_data_q  <= pixel_data_d;
      pixel_valid_q <= pixel_valid_d;
      pixel_index_q <= pixel_index_d;
      frame_done_q  <= frame_done_d;
      frame_px_q    <= frame_px_d;
      err_q         <= err_d;
      err_sticky_q  <= err_sticky_d;
    end
  end

  assign pixel_data     = pixel_data_q;
  assign pixel_valid    = pixel_valid_q;
  assign pixel_index    = pixel_index_q;
  assign frame_done     = frame_done_q;
  assign frame_px_count = frame_px_q;
  assign err            = err_q;
  assign err_sticky     = err_sticky_q;

endmodule

// File: doc/ws2812_decoder.md
Name: ws2812_decoder

Overview:
Receives a WS2812/NeoPixel single-wire NRZ stream, as produced by the strip driver, and recovers the 24-bit pixel words plus frame boundaries. It is used for loopback self-test of the LED output path and for capturing frames from an external source. It runs in the 100 MHz system clock domain and classifies bits by measuring the high-pulse width in clock cycles.

Parameters:
PX_COUNT_WIDTH, 6, width of pixel_index and frame_px_count
BITS_PER_PIXEL, 24, bits assembled per pixel word, MSB first
MIN_HIGH, 15, high pulses shorter than this many cycles are a glitch error
BIT_THRESH, 60, high width >= BIT_THRESH decodes as 1, otherwise 0
MAX_HIGH, 120, high width > MAX_HIGH is a stuck-high error
RESET_CYCLES, 5000, low time in cycles that marks a latch/reset gap (50 us)

Ports:
clk  in  1  system clock, 100 MHz
rst  in  1  synchronous reset, active-high
din  in  1  raw serial line; asynchronous to clk
pixel_data  out  BITS_PER_PIXEL  last completed pixel word, GRB order as received
pixel_valid  out  1  one-cycle pulse when pixel_data updates
pixel_index  out  PX_COUNT_WIDTH  index of pixel_data within the current frame, 0-based
frame_done  out  1  one-cycle pulse on a valid latch gap ending a frame
frame_px_count  out  PX_COUNT_WIDTH  pixels received in the frame just ended; valid with frame_done
err  out  1  one-cycle pulse on any protocol error
err_sticky  out  1  set by any err; cleared only by rst

Behaviour:
- Reset: all outputs are 0. Bit, pixel and cycle counters are cleared. The state becomes WAIT_GAP.
- Input sync: din passes through a 2-FF synchronizer to din_s. All edges refer to din_s and its registered previous value.
- High counter: counts cycles with din_s=1 and saturates at MAX_HIGH+1. Low counter: counts cycles with din_s=0 and saturates at RESET_CYCLES.
- States:
  - WAIT_GAP: any high clears the low counter. On low counter = RESET_CYCLES, go to IDLE. No frame_done is issued. This state prevents locking on mid-stream.
  - IDLE: on a rising edge, go to HIGH. pixel_index and the bit counter are 0.
  - HIGH: on a falling edge, classify the measured width w:
    - w < MIN_HIGH: err, go to ERROR.
    - w >= BIT_THRESH: shift in 1, go to LOW.
    - otherwise: shift in 0, go to LOW.
    - If w reaches MAX_HIGH+1 while still high: err, go to ERROR immediately.
  - LOW: on a rising edge, go to HIGH. On low counter = RESET_CYCLES, end the frame (see gap rules) and go to IDLE.
  - ERROR: behaves as WAIT_GAP, then returns to IDLE. The partial pixel is discarded. No pixel_valid and no frame_done are issued for the aborted frame.
- Bit assembly: bits shift in MSB first. On the BITS_PER_PIXEL-th bit:
  - pixel_data is loaded and pixel_valid pulses on the cycle after the falling edge is detected.
  - pixel_index gives that pixel's index, then the internal pixel counter increments. It wraps modulo 2^PX_COUNT_WIDTH.
  - The bit counter returns to 0.
- Gap rules:
  - If the bit counter = 0 and at least one pixel was received, frame_done pulses and frame_px_count = pixel count (wrapped).
  - If the bit counter != 0, err pulses, there is no frame_done, and the counters clear.
  - A gap with zero pixels produces no pulse.
- Latency: pixel_valid follows the final falling edge of din by 3 clk cycles (2 sync + 1 register). frame_done asserts RESET_CYCLES low cycles after the last falling edge, plus 3.
- err and pixel_valid can never coincide. The frame_done and err gap outcomes are mutually exclusive.
- rst asserted mid-frame aborts the frame immediately, with no outputs pulsing. The block resumes in WAIT_GAP.
- pixel_data holds its value between pixel_valid pulses.

Test Plan:
1. rst, din low 5000+ cycles, then 24 bits encoding 0xFF8001 (1-bits = 80 high/45 low, 0-bits = 40 high/85 low), then low 5000 -> one pixel_valid with pixel_data=0xFF8001, pixel_index=0; frame_done with frame_px_count=1; err never.
2. Three pixels 0x000000, 0xFFFFFF, 0x123456 back-to-back, then gap -> pixel_valid at indices 0,1,2 with those values; frame_done, frame_px_count=3.
3. After a valid gap, a 10-cycle high pulse -> err pulse, err_sticky=1. The following 24 bits are ignored until a 5000-cycle gap. The next frame of 0xA5A5A5 decodes normally.
4. 12 bits then 5000 low -> err pulse, no frame_done, no pixel_valid. The next full pixel gets pixel_index=0.
5. Start driving bits 0xABCDEF right after rst without a preceding gap -> no pixel_valid until a 5000-cycle low is seen. Boundary checks: 59-cycle high decodes 0, 60 decodes 1, 121 gives err.
6. rst pulsed after 16 bits of a pixel -> all outputs 0, err_sticky=0. Resending a full gap plus 0x00FF00 yields pixel_valid with index 0.
